audio_dma_resp: RTL and testbench

AUDIO_DMA_RESP -- requirements
Module: audio_dma_resp

---
 rtl/audio_dma_resp.sv | 172 +++++++++++++++++
 tb/tb_audio_dma_resp.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_dma_resp.sv
// Audio mixer fetch responder: turns a held audio request into one VRAM or
// TILEMEM read, returns the word with a one-cycle ack, and flags starvation.
module audio_dma_resp #(
  parameter int TILE_WORDS    = 5120,
  parameter int URGENT_CYCLES = 8
) (
  input  logic        clk,
  input  logic        reset_i,
  input  logic        audio_req_i,
  input  logic        audio_tile_i,
  input  logic [15:0] audio_addr_i,
  output logic        audio_ack_o,
  output logic [15:0] audio_word_o,
  output logic        vram_sel_o,
  output logic [15:0] vram_addr_o,
  input  logic        vram_grant_i,
  input  logic [15:0] vram_data_i,
  output logic        tile_sel_o,
  output logic [12:0] tile_addr_o,
  input  logic        tile_grant_i,
  input  logic [15:0] tile_data_i,
  output logic        urgent_o
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WAIT = 3'd1,
    READ = 3'd2,
    ACK  = 3'd3,
    HOLD = 3'd4
  } state_t;

  localparam logic [16:0] TILE_LIMIT = 17'(TILE_WORDS);
  localparam logic [3:0]  URGENT_LIM = 4'(URGENT_CYCLES);

  state_t      state_r, state_s;
  logic        tile_r, tile_s;
  logic        oor_r, oor_s;
  logic [3:0]  cnt_r, cnt_s;
  logic        ack_r, ack_s;
  logic [15:0] word_r, word_s;
  logic        vsel_r, vsel_s;
  logic [15:0] vaddr_r, vaddr_s;
  logic        tsel_r, tsel_s;
  logic [12:0] taddr_r, taddr_s;
  logic        urgent_r, urgent_s;
  logic        gnt_s;
  logic [15:0] rdata_s;
  logic        oor_req_s;

  assign gnt_s     = tile_r ? tile_grant_i : vram_grant_i;
  assign rdata_s   = tile_r ? tile_data_i : vram_data_i;
  assign oor_req_s = ({1'b0, audio_addr_i} >= TILE_LIMIT);

  // Next-state and next-output logic; every output is a register loaded from here.
  always_comb begin
    state_s  = state_r;
    tile_s   = tile_r;
    oor_s    = oor_r;
    cnt_s    = cnt_r;
    ack_s    = 1'b0;
    word_s   = word_r;
    vsel_s   = vsel_r;
    vaddr_s  = vaddr_r;
    tsel_s   = tsel_r;
    taddr_s  = taddr_r;
    urgent_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (audio_req_i) begin
          tile_s = audio_tile_i;
          cnt_s  = 4'd0;
          // Out-of-range tile reads borrow the READ slot with no memory
          // select so the zero word is acked at a fixed latency.
          if (audio_tile_i && oor_req_s) begin
            oor_s   = 1'b1;
            word_s  = 16'h0000;
            state_s = READ;
          end else begin
            oor_s   = 1'b0;
            state_s = WAIT;
            if (audio_tile_i) begin
              tsel_s  = 1'b1;
              taddr_s = audio_addr_i[12:0];
            end else begin
              vsel_s  = 1'b1;
              vaddr_s = audio_addr_i;
            end
          end
        end else begin
          state_s = IDLE;
        end
      end
      WAIT: begin
        if (!audio_req_i) begin
          vsel_s  = 1'b0;
          tsel_s  = 1'b0;
          state_s = IDLE;
        end else if (gnt_s) begin
          vsel_s  = 1'b0;
          tsel_s  = 1'b0;
          state_s = READ;
        end else begin
          if (cnt_r != 4'hF) begin
            cnt_s = cnt_r + 4'd1;
          end else begin
            cnt_s = cnt_r;
          end
          urgent_s = (cnt_s >= URGENT_LIM);
        end
      end
      READ: begin
        if (oor_r) begin
          word_s = 16'h0000;
        end else begin
          word_s = rdata_s;
        end
        ack_s   = 1'b1;
        state_s = ACK;
      end
      ACK: begin
        state_s = HOLD;
      end
      HOLD: begin
        state_s = IDLE;
      end
      default: begin
        vsel_s  = 1'b0;
        tsel_s  = 1'b0;
        state_s = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset_i) begin
      state_r  <= IDLE;
      tile_r   <= 1'b0;
      oor_r    <= 1'b0;
      cnt_r    <= 4'd0;
      ack_r    <= 1'b0;
      word_r   <= 16'h0000;
      vsel_r   <= 1'b0;
      vaddr_r  <= 16'h0000;
      tsel_r   <= 1'b0;
      taddr_r  <= 13'h0000;
      urgent_r <= 1'b0;
    end else begin
      state_r  <= state_s;
      tile_r   <= tile_s;
      oor_r    <= oor_s;
      cnt_r    <= cnt_s;
      ack_r    <= ack_s;
      word_r   <= word_s;
      vsel_r   <= vsel_s;
      vaddr_r  <= vaddr_s;
      tsel_r   <= tsel_s;
      taddr_r  <= taddr_s;
      urgent_r <= urgent_s;
    end
  end

  assign audio_ack_o  = ack_r;
  assign audio_word_o = word_r;
  assign vram_sel_o   = vsel_r;
  assign vram_addr_o  = vaddr_r;
  assign tile_sel_o   = tsel_r;
  assign tile_addr_o  = taddr_r;
  assign urgent_o     = urgent_r;

endmodule

// File: tb/tb_audio_dma_resp.sv
// Directed bench for audio_dma_resp: cycle-accurate checks of fetch, out of
// range, starvation, abort, reset and held-request behaviour.
module tb_audio_dma_resp;

  logic        clk = 1'b0;
  logic        reset_i = 1'b0;
  logic        audio_req_i = 1'b0;
  logic        audio_tile_i = 1'b0;
  logic [15:0] audio_addr_i = 16'h0000;
  logic        audio_ack_o;
  logic [15:0] audio_word_o;
  logic        vram_sel_o;
  logic [15:0] vram_addr_o;
  logic        vram_grant_i = 1'b0;
  logic [15:0] vram_data_i = 16'h0000;
  logic        tile_sel_o;
  logic [12:0] tile_addr_o;
  logic        tile_grant_i = 1'b0;
  logic [15:0] tile_data_i = 16'h0000;
  logic        urgent_o;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  audio_dma_resp #(.TILE_WORDS(5120), .URGENT_CYCLES(8)) dut (
    .clk(clk), .reset_i(reset_i),
    .audio_req_i(audio_req_i), .audio_tile_i(audio_tile_i), .audio_addr_i(audio_addr_i),
    .audio_ack_o(audio_ack_o), .audio_word_o(audio_word_o),
    .vram_sel_o(vram_sel_o), .vram_addr_o(vram_addr_o),
    .vram_grant_i(vram_grant_i), .vram_data_i(vram_data_i),
    .tile_sel_o(tile_sel_o), .tile_addr_o(tile_addr_o),
    .tile_grant_i(tile_grant_i), .tile_data_i(tile_data_i),
    .urgent_o(urgent_o)
  );

  // Start of a cycle: just after the active edge, where inputs are driven.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Mid-cycle sampling point for outputs.
  task automatic sample();
    @(negedge clk);
  endtask

  task automatic test_reset();
    tick();
    reset_i = 1'b1;
    tick();
    sample();
    checks++;
    if ({audio_ack_o, audio_word_o, vram_sel_o, vram_addr_o, tile_sel_o, tile_addr_o, urgent_o} !== 49'd0) begin
      failures++;
      $display("FAIL reset_outputs act ack=%0b word=%h vsel=%0b vaddr=%h tsel=%0b taddr=%h urg=%0b exp all zero",
               audio_ack_o, audio_word_o, vram_sel_o, vram_addr_o, tile_sel_o, tile_addr_o, urgent_o);
    end
    tick();
    reset_i = 1'b0;
  endtask

  task automatic test_vram_fetch();
    tick(); // cycle 0
    audio_req_i = 1'b1; audio_tile_i = 1'b0; audio_addr_i = 16'h1234;
    sample();
    checks++;
    if (audio_ack_o !== 1'b0) begin failures++; $display("FAIL vram_c0_ack act=%0b exp=0", audio_ack_o); end
    tick(); // cycle 1
    vram_grant_i = 1'b1;
    sample();
    checks++;
    if ({vram_sel_o, tile_sel_o, vram_addr_o} !== {1'b1, 1'b0, 16'h1234}) begin
      failures++; $display("FAIL vram_c1_sel act vsel=%0b tsel=%0b vaddr=%h exp 1 0 1234", vram_sel_o, tile_sel_o, vram_addr_o);
    end
    tick(); // cycle 2
    vram_grant_i = 1'b0; vram_data_i = 16'hBEEF;
    sample();
    checks++;
    if ({vram_sel_o, audio_ack_o} !== 2'b00) begin
      failures++; $display("FAIL vram_c2_read act vsel=%0b ack=%0b exp 0 0", vram_sel_o, audio_ack_o);
    end
    tick(); // cycle 3
    vram_data_i = 16'h0000;
    sample();
    checks++;
    if ({audio_ack_o, audio_word_o} !== {1'b1, 16'hBEEF}) begin
      failures++; $display("FAIL vram_c3_ack act ack=%0b word=%h exp 1 beef", audio_ack_o, audio_word_o);
    end
    tick(); // cycle 4
    audio_req_i = 1'b0;
    sample();
    checks++;
    if ({audio_ack_o, audio_word_o} !== {1'b0, 16'hBEEF}) begin
      failures++; $display("FAIL vram_c4_ackoff act ack=%0b word=%h exp 0 beef", audio_ack_o, audio_word_o);
    end
  endtask

  task automatic test_tile_fetch();
    tick(); // cycle 0
    audio_req_i = 1'b1; audio_tile_i = 1'b1; audio_addr_i = 16'h0100;
    sample();
    for (int c = 1; c <= 4; c++) begin
      tick();
      vram_grant_i = (c == 1); // grant on the wrong memory must be ignored
      tile_grant_i = (c == 4);
      sample();
      checks++;
      if ({tile_sel_o, vram_sel_o, tile_addr_o, audio_ack_o} !== {1'b1, 1'b0, 13'h0100, 1'b0}) begin
        failures++; $display("FAIL tile_wait_c%0d act tsel=%0b vsel=%0b taddr=%h ack=%0b exp 1 0 0100 0",
                             c, tile_sel_o, vram_sel_o, tile_addr_o, audio_ack_o);
      end
    end
    tick(); // cycle 5
    tile_grant_i = 1'b0; vram_grant_i = 1'b0; tile_data_i = 16'h5A5A;
    sample();
    checks++;
    if ({tile_sel_o, vram_sel_o, audio_ack_o} !== 3'b000) begin
      failures++; $display("FAIL tile_c5_read act tsel=%0b vsel=%0b ack=%0b exp 0 0 0", tile_sel_o, vram_sel_o, audio_ack_o);
    end
    tick(); // cycle 6
    tile_data_i = 16'h0000;
    sample();
    checks++;
    if ({audio_ack_o, audio_word_o, vram_sel_o} !== {1'b1, 16'h5A5A, 1'b0}) begin
      failures++; $display("FAIL tile_c6_ack act ack=%0b word=%h vsel=%0b exp 1 5a5a 0", audio_ack_o, audio_word_o, vram_sel_o);
    end
    tick(); // cycle 7
    audio_req_i = 1'b0;
    sample();
  endtask

  task automatic test_out_of_range();
    tick(); // cycle 0
    audio_req_i = 1'b1; audio_tile_i = 1'b1; audio_addr_i = 16'h1400;
    sample();
    tick(); // cycle 1
    sample();
    checks++;
    if ({tile_sel_o, vram_sel_o, audio_ack_o} !== 3'b000) begin
      failures++; $display("FAIL oor_c1 act tsel=%0b vsel=%0b ack=%0b exp 0 0 0", tile_sel_o, vram_sel_o, audio_ack_o);
    end
    tick(); // cycle 2
    sample();
    checks++;
    if ({audio_ack_o, audio_word_o, tile_sel_o} !== {1'b1, 16'h0000, 1'b0}) begin
      failures++; $display("FAIL oor_c2_ack act ack=%0b word=%h tsel=%0b exp 1 0000 0", audio_ack_o, audio_word_o, tile_sel_o);
    end
    tick(); // cycle 3
    audio_req_i = 1'b0; audio_tile_i = 1'b0;
    sample();
    checks++;
    if (audio_ack_o !== 1'b0) begin failures++; $display("FAIL oor_c3_ackoff act=%0b exp=0", audio_ack_o); end
  endtask

  task automatic test_starvation();
    logic exp_urg;
    tick(); // cycle 0
    audio_req_i = 1'b1; audio_tile_i = 1'b0; audio_addr_i = 16'h0042;
    sample();
    for (int c = 1; c <= 13; c++) begin
      tick();
      vram_grant_i = (c == 13);
      sample();
      exp_urg = (c >= 9);
      checks++;
      if ({urgent_o, vram_sel_o, audio_ack_o} !== {exp_urg, 1'b1, 1'b0}) begin
        failures++; $display("FAIL starve_c%0d act urg=%0b vsel=%0b ack=%0b exp %0b 1 0", c, urgent_o, vram_sel_o, audio_ack_o, exp_urg);
      end
    end
    tick(); // cycle 14
    vram_grant_i = 1'b0; vram_data_i = 16'h1111;
    sample();
    checks++;
    if ({urgent_o, vram_sel_o, audio_ack_o} !== 3'b000) begin
      failures++; $display("FAIL starve_c14 act urg=%0b vsel=%0b ack=%0b exp 0 0 0", urgent_o, vram_sel_o, audio_ack_o);
    end
    tick(); // cycle 15
    vram_data_i = 16'h0000;
    sample();
    checks++;
    if ({audio_ack_o, audio_word_o, urgent_o} !== {1'b1, 16'h1111, 1'b0}) begin
      failures++; $display("FAIL starve_c15_ack act ack=%0b word=%h urg=%0b exp 1 1111 0", audio_ack_o, audio_word_o, urgent_o);
    end
    tick(); // cycle 16
    audio_req_i = 1'b0;
    sample();
  endtask

  task automatic test_abort();
    tick(); // cycle 0
    audio_req_i = 1'b1; audio_tile_i = 1'b0; audio_addr_i = 16'h0077;
    sample();
    tick(); // cycle 1
    sample();
    checks++;
    if (vram_sel_o !== 1'b1) begin failures++; $display("FAIL abort_c1_sel act=%0b exp=1", vram_sel_o); end
    tick(); // cycle 2: initiator drops the request while waiting
    audio_req_i = 1'b0;
    sample();
    tick(); // cycle 3
    sample();
    checks++;
    if ({vram_sel_o, audio_ack_o, audio_word_o} !== {1'b0, 1'b0, 16'h1111}) begin
      failures++; $display("FAIL abort_c3 act vsel=%0b ack=%0b word=%h exp 0 0 1111", vram_sel_o, audio_ack_o, audio_word_o);
    end
    tick(); // cycle 4: new request must be accepted straight from IDLE
    audio_req_i = 1'b1; audio_tile_i = 1'b1; audio_addr_i = 16'h0200;
    sample();
    checks++;
    if (audio_ack_o !== 1'b0) begin failures++; $display("FAIL abort_c4_noack act=%0b exp=0", audio_ack_o); end
    tick(); // cycle 5
    tile_grant_i = 1'b1;
    sample();
    checks++;
    if ({tile_sel_o, tile_addr_o} !== {1'b1, 13'h0200}) begin
      failures++; $display("FAIL abort_restart_sel act tsel=%0b taddr=%h exp 1 0200", tile_sel_o, tile_addr_o);
    end
    tick(); // cycle 6
    tile_grant_i = 1'b0; tile_data_i = 16'h2222;
    sample();
    tick(); // cycle 7
    tile_data_i = 16'h0000;
    sample();
    checks++;
    if ({audio_ack_o, audio_word_o} !== {1'b1, 16'h2222}) begin
      failures++; $display("FAIL abort_restart_ack act ack=%0b word=%h exp 1 2222", audio_ack_o, audio_word_o);
    end
    tick(); // cycle 8
    audio_req_i = 1'b0; audio_tile_i = 1'b0;
    sample();
  endtask

  task automatic test_reset_in_wait();
    tick(); // cycle 0
    audio_req_i = 1'b1; audio_tile_i = 1'b0; audio_addr_i = 16'h0099;
    sample();
    tick(); // cycle 1
    sample();
    tick(); // cycle 2: reset coincides with the grant
    reset_i = 1'b1; vram_grant_i = 1'b1;
    sample();
    tick(); // cycle 3
    reset_i = 1'b0; vram_grant_i = 1'b0; vram_data_i = 16'h3333; audio_req_i = 1'b0;
    sample();
    checks++;
    if ({audio_ack_o, audio_word_o, vram_sel_o, vram_addr_o, tile_sel_o, tile_addr_o, urgent_o} !== 49'd0) begin
      failures++; $display("FAIL rstwait_outputs act ack=%0b word=%h vsel=%0b vaddr=%h tsel=%0b taddr=%h urg=%0b exp all zero",
                           audio_ack_o, audio_word_o, vram_sel_o, vram_addr_o, tile_sel_o, tile_addr_o, urgent_o);
    end
    tick(); // cycle 4: late grant
    vram_grant_i = 1'b1;
    sample();
    for (int c = 5; c <= 6; c++) begin
      tick();
      vram_grant_i = 1'b0;
      sample();
      checks++;
      if ({audio_ack_o, vram_sel_o} !== 2'b00) begin
        failures++; $display("FAIL rstwait_c%0d act ack=%0b vsel=%0b exp 0 0", c, audio_ack_o, vram_sel_o);
      end
    end
    vram_data_i = 16'h0000;
  endtask

  task automatic test_back_to_back();
    int acks;
    acks = 0;
    tick(); // cycle 0
    audio_req_i = 1'b1; audio_tile_i = 1'b0; audio_addr_i = 16'h0005;
    sample();
    for (int c = 1; c <= 9; c++) begin
      tick();
      vram_grant_i = (c == 1);
      vram_data_i  = (c == 2) ? 16'h4444 : 16'h0000;
      if (c == 5) audio_req_i = 1'b0;
      if (c == 6) begin audio_req_i = 1'b1; audio_tile_i = 1'b1; audio_addr_i = 16'h0010; end
      tile_grant_i = (c == 7);
      tile_data_i  = (c == 8) ? 16'h5555 : 16'h0000;
      sample();
      if (audio_ack_o === 1'b1) acks++;
      if (c == 3) begin
        checks++;
        if ({audio_ack_o, audio_word_o} !== {1'b1, 16'h4444}) begin
          failures++; $display("FAIL b2b_first_ack act ack=%0b word=%h exp 1 4444", audio_ack_o, audio_word_o);
        end
      end
      if (c == 5) begin
        checks++;
        if ({vram_sel_o, tile_sel_o, audio_ack_o} !== 3'b000) begin
          failures++; $display("FAIL b2b_hold_ignore act vsel=%0b tsel=%0b ack=%0b exp 0 0 0", vram_sel_o, tile_sel_o, audio_ack_o);
        end
      end
      if (c == 7) begin
        checks++;
        if ({tile_sel_o, vram_sel_o} !== 2'b10) begin
          failures++; $display("FAIL b2b_second_sel act tsel=%0b vsel=%0b exp 1 0", tile_sel_o, vram_sel_o);
        end
      end
      if (c == 9) begin
        checks++;
        if ({audio_ack_o, audio_word_o} !== {1'b1, 16'h5555}) begin
          failures++; $display("FAIL b2b_second_ack act ack=%0b word=%h exp 1 5555", audio_ack_o, audio_word_o);
        end
      end
    end
    tick(); // cycle 10
    audio_req_i = 1'b0; audio_tile_i = 1'b0;
    sample();
    if (audio_ack_o === 1'b1) acks++;
    checks++;
    if (acks !== 2) begin failures++; $display("FAIL b2b_ack_count act=%0d exp=2", acks); end
  endtask

  initial begin
    test_reset();
    test_vram_fetch();
    test_tile_fetch();
    test_out_of_range();
    test_starvation();
    test_abort();
    test_reset_in_wait();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
